branch_pred_unit: RTL and testbench
===================================

BRANCH_PRED_UNIT -- requirements
Module: branch_pred_unit

Interface
REQ-001 The block SHALL have one clock, clk, and one reset, rst, which is synchronous and active-high.
REQ-002 Parameter DATA_W, 32, SHALL set the width of the compared operands.
REQ-003 Parameter PHT_DEPTH, 64, SHALL set the number of pattern-history-table entries; it is a power of two, 4..1024.
REQ-004 Port clk  in  1  rising-edge clock.
REQ-005 Port rst  in  1  synchronous active-high reset.
REQ-006 Port if_pc  in  32  fetch-stage PC used for prediction lookup.
REQ-007 Port pred_taken  out  1  combinational prediction for if_pc.
REQ-008 Port id_valid  in  1  decode-stage instruction valid.
REQ-009 Port stallD  in  1  decode stall; no acceptance while high.
REQ-010 Port flushD  in  1  decode flush; no acceptance while high.
REQ-011 Port id_op  in  6  opcode field; id_rt  in  5  rt field.
REQ-012 Port id_a, id_b  in  DATA_W  forwarded rs and rt operands.
REQ-013 Port id_pc  in  32  PC of the decode-stage instruction.
REQ-014 Port id_pred_taken  in  1  prediction that travelled with the instruction.
REQ-015 Port res_valid  out  1  one-cycle pulse marking a resolved branch.
REQ-016 Port res_taken  out  1  actual outcome of the resolved branch.
REQ-017 Port mispredict  out  1  asserted when res_taken differs from the carried prediction.

Function
REQ-018 Branch decode and taken conditions SHALL be as follows, with all relational compares signed at DATA_W:
  - BEQ 000100: a==b
  - BNE 000101: a!=b
  - BLEZ 000110: a<=0
  - BGTZ 000111: a>0
  - REGIMM 000001 with rt 00001 or 10001: a>=0
  - REGIMM 000001 with rt 00000 or 10000: a<0
  - every other op/rt combination is not a branch.
REQ-019 A branch SHALL be accepted on a clock edge where id_valid=1, stallD=0, flushD=0 and the op/rt combination decodes as a branch.
REQ-020 On acceptance, res_valid, res_taken and mispredict SHALL be registered with latency 1:
  - res_valid=1
  - res_taken=condition result
  - mispredict=res_taken XOR id_pred_taken.
REQ-021 Without an acceptance, res_valid and mispredict SHALL be 0 on the next cycle, and res_taken SHALL hold its last value.
REQ-022 If flushD and stallD are both high on the same edge, flushD SHALL win: no acceptance, no table update.
REQ-023 The PHT SHALL hold PHT_DEPTH 2-bit saturating counters, indexed by pc[log2(PHT_DEPTH)+1:2].
REQ-024 pred_taken SHALL equal bit 1 of the counter at if_pc's index.
REQ-025 On acceptance, the counter at id_pc's index SHALL update at the same edge: +1 if taken, saturating at 11; -1 if not taken, saturating at 00.
REQ-026 A same-edge lookup and update of one index SHALL return the pre-update value (no bypass).
REQ-027 Non-branch instructions SHALL never modify the PHT.

Reset
REQ-028 While rst=1, res_valid, res_taken and mispredict SHALL be 0 at the next edge.
REQ-029 While rst=1, every PHT counter SHALL be set to 01 (weakly not taken) at the next edge.
REQ-030 A branch presented in the same cycle as rst=1 SHALL be discarded, with no update.
REQ-031 Reset SHALL have priority over every other input.

Configuration
REQ-032 With macro BRANCH_STATS_EN defined, the block SHALL add outputs br_count out 32 and miss_count out 32:
  - br_count increments on each acceptance
  - miss_count increments on each acceptance whose mispredict result is 1
  - both wrap from FFFFFFFF to 0
  - both reset to 0.
REQ-033 Without BRANCH_STATS_EN, these ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-034 Reset, then if_pc=0x100 -> pred_taken=0; every index reads counter 01.
REQ-035 BEQ, a=b=0x5, id_pc=0x100, id_pred_taken=0 -> next cycle res_valid=1, res_taken=1, mispredict=1; the same if_pc then gives pred_taken=1.
REQ-036 BGEZAL (op 000001, rt 10001), a=0x80000000 -> res_taken=0; BLTZ with the same a -> res_taken=1.
REQ-037 Four taken BNE at id_pc=0x200 -> counter saturates at 11; one not-taken -> 10, and pred_taken stays 1.
REQ-038 Valid BEQ with stallD=1, then with flushD=1, then with rst=1 -> res_valid stays 0 and the PHT is unchanged each time.
REQ-039 With BRANCH_STATS_EN, preload br_count near wrap (FFFFFFFF), then one mispredicted branch -> br_count=0, miss_count increments by 1.

Source files
------------

// File: rtl/branch_pred_unit.sv
// Branch resolver with a 2-bit saturating-counter pattern history table.
// Optional macro BRANCH_STATS_EN adds branch/mispredict counters.
module branch_pred_unit #(
  parameter int DATA_W    = 32,
  parameter int PHT_DEPTH = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       if_pc,
  output logic              pred_taken,
  input  logic              id_valid,
  input  logic              stallD,
  input  logic              flushD,
  input  logic [5:0]        id_op,
  input  logic [4:0]        id_rt,
  input  logic [DATA_W-1:0] id_a,
  input  logic [DATA_W-1:0] id_b,
  input  logic [31:0]       id_pc,
  input  logic              id_pred_taken,
  output logic              res_valid,
  output logic              res_taken,
  output logic              mispredict
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]       br_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int IDX_W = $clog2(PHT_DEPTH);

  logic [1:0]       pht [PHT_DEPTH];
  logic [IDX_W-1:0] if_idx;
  logic [IDX_W-1:0] id_idx;
  logic [1:0]       ctr;
  logic [1:0]       ctr_next;
  logic             is_branch;
  logic             cond;
  logic             a_neg;
  logic             a_zero;
  logic             accept;
  logic             unused;

  assign if_idx     = if_pc[IDX_W+1:2];
  assign id_idx     = id_pc[IDX_W+1:2];
  assign pred_taken = pht[if_idx][1];
  assign unused     = ^{if_pc[31:IDX_W+2], if_pc[1:0], id_pc[31:IDX_W+2], id_pc[1:0]};

  assign a_neg  = id_a[DATA_W-1];
  assign a_zero = (id_a == '0);

  always_comb begin
    is_branch = 1'b0;
    cond      = 1'b0;
    case (id_op)
      6'b000100: begin is_branch = 1'b1; cond = (id_a == id_b);       end
      6'b000101: begin is_branch = 1'b1; cond = (id_a != id_b);       end
      6'b000110: begin is_branch = 1'b1; cond = a_neg | a_zero;       end
      6'b000111: begin is_branch = 1'b1; cond = ~a_neg & ~a_zero;     end
      6'b000001: begin
        case (id_rt)
          5'b00001, 5'b10001: begin is_branch = 1'b1; cond = ~a_neg; end
          5'b00000, 5'b10000: begin is_branch = 1'b1; cond = a_neg;  end
          default:            begin is_branch = 1'b0; cond = 1'b0;   end
        endcase
      end
      default: begin is_branch = 1'b0; cond = 1'b0; end
    endcase
  end

  assign accept = id_valid & ~stallD & ~flushD & is_branch;
  assign ctr    = pht[id_idx];

  always_comb begin
    ctr_next = ctr;
    if (cond) begin
      if (ctr != 2'b11) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) ctr_next = ctr - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid  <= 1'b0;
      res_taken  <= 1'b0;
      mispredict <= 1'b0;
      for (int unsigned i = 0; i < unsigned'(PHT_DEPTH); i++) pht[i] <= 2'b01;
    end else begin
      res_valid  <= accept;
      mispredict <= accept & (cond ^ id_pred_taken);
      if (accept) begin
        res_taken   <= cond;
        pht[id_idx] <= ctr_next;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      br_count   <= '0;
      miss_count <= '0;
    end else if (accept) begin
      br_count <= br_count + 32'd1;
      if (cond ^ id_pred_taken) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_pred_unit.sv
// Self-checking bench for branch_pred_unit: decode table, directed sequences,
// and randomized traffic against an array-based reference model.
module tb_branch_pred_unit;
  localparam int DATA_W    = 32;
  localparam int PHT_DEPTH = 64;

  logic              clk;
  logic              rst;
  logic [31:0]       if_pc;
  logic              pred_taken;
  logic              id_valid;
  logic              stallD;
  logic              flushD;
  logic [5:0]        id_op;
  logic [4:0]        id_rt;
  logic [DATA_W-1:0] id_a;
  logic [DATA_W-1:0] id_b;
  logic [31:0]       id_pc;
  logic              id_pred_taken;
  logic              res_valid;
  logic              res_taken;
  logic              mispredict;
`ifdef BRANCH_STATS_EN
  logic [31:0]       br_count;
  logic [31:0]       miss_count;
`endif

  branch_pred_unit #(.DATA_W(DATA_W), .PHT_DEPTH(PHT_DEPTH)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken),
    .id_valid(id_valid), .stallD(stallD), .flushD(flushD),
    .id_op(id_op), .id_rt(id_rt), .id_a(id_a), .id_b(id_b),
    .id_pc(id_pc), .id_pred_taken(id_pred_taken),
    .res_valid(res_valid), .res_taken(res_taken), .mispredict(mispredict)
`ifdef BRANCH_STATS_EN
    , .br_count(br_count), .miss_count(miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference state: counters as plain integers 0..3
  int mpht [PHT_DEPTH];
  bit m_valid, m_taken, m_mis, live;
  int unsigned m_br, m_miss;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % PHT_DEPTH);
  endfunction

  function automatic void ref_decode(input logic [5:0] op, input logic [4:0] rt,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output bit br, output bit tk);
    int sa;
    sa = int'(a);
    br = 1'b1;
    tk = 1'b0;
    case (op)
      6'd4: tk = (a == b);
      6'd5: tk = (a != b);
      6'd6: tk = (sa <= 0);
      6'd7: tk = (sa > 0);
      6'd1: begin
        if (rt == 5'd1 || rt == 5'd17)      tk = (sa >= 0);
        else if (rt == 5'd0 || rt == 5'd16) tk = (sa < 0);
        else br = 1'b0;
      end
      default: br = 1'b0;
    endcase
  endfunction

  task automatic apply(input bit r, input bit v, input bit s, input bit f,
                       input logic [5:0] op, input logic [4:0] rt,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input bit pr, input logic [31:0] ipc);
    bit br, tk;
    int k;
    rst = r; id_valid = v; stallD = s; flushD = f; id_op = op; id_rt = rt;
    id_a = a; id_b = b; id_pc = pc; id_pred_taken = pr; if_pc = ipc;
    #1;
    if (live) check("pred_taken", {31'd0, pred_taken}, 32'(mpht[idx_of(ipc)] / 2));
    ref_decode(op, rt, a, b, br, tk);
    if (r) begin
      for (int i = 0; i < PHT_DEPTH; i++) mpht[i] = 1;
      m_valid = 0; m_taken = 0; m_mis = 0; m_br = 0; m_miss = 0;
      live = 1;
    end else if (v && !s && !f && br) begin
      k = idx_of(pc);
      m_valid = 1; m_taken = tk; m_mis = tk ^ pr;
      mpht[k] = tk ? ((mpht[k] == 3) ? 3 : mpht[k] + 1) : ((mpht[k] == 0) ? 0 : mpht[k] - 1);
      m_br++;
      if (tk ^ pr) m_miss++;
    end else begin
      m_valid = 0; m_mis = 0;
    end
    @(posedge clk);
    #1;
    if (live) begin
      check("res_valid", {31'd0, res_valid}, {31'd0, m_valid});
      check("res_taken", {31'd0, res_taken}, {31'd0, m_taken});
      check("mispredict", {31'd0, mispredict}, {31'd0, m_mis});
`ifdef BRANCH_STATS_EN
      check("br_count", br_count, m_br);
      check("miss_count", miss_count, m_miss);
`endif
    end
  endtask

  task automatic do_reset();
    apply(1, 0, 0, 0, 6'd0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 32'd0);
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rt;
    logic [31:0] a;
    logic [31:0] b;
    bit          br;
    bit          tk;
  } vec_t;

  vec_t vecs [17];

  logic [31:0] pick_vals [6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    live = 0;
    pick_vals[0] = 32'h0; pick_vals[1] = 32'h1; pick_vals[2] = 32'hFFFF_FFFF;
    pick_vals[3] = 32'h8000_0000; pick_vals[4] = 32'h7FFF_FFFF; pick_vals[5] = 32'h5;

    vecs[0]  = '{6'd4, 5'd0,  32'h5,         32'h5, 1, 1};
    vecs[1]  = '{6'd4, 5'd0,  32'h5,         32'h6, 1, 0};
    vecs[2]  = '{6'd5, 5'd0,  32'h5,         32'h6, 1, 1};
    vecs[3]  = '{6'd5, 5'd0,  32'h7,         32'h7, 1, 0};
    vecs[4]  = '{6'd6, 5'd0,  32'h0,         32'h0, 1, 1};
    vecs[5]  = '{6'd6, 5'd0,  32'h1,         32'h0, 1, 0};
    vecs[6]  = '{6'd6, 5'd0,  32'h8000_0000, 32'h0, 1, 1};
    vecs[7]  = '{6'd7, 5'd0,  32'h1,         32'h0, 1, 1};
    vecs[8]  = '{6'd7, 5'd0,  32'h0,         32'h0, 1, 0};
    vecs[9]  = '{6'd7, 5'd0,  32'hFFFF_FFFF, 32'h0, 1, 0};
    vecs[10] = '{6'd1, 5'd1,  32'h0,         32'h0, 1, 1};
    vecs[11] = '{6'd1, 5'd17, 32'h8000_0000, 32'h0, 1, 0};
    vecs[12] = '{6'd1, 5'd0,  32'hFFFF_FFFF, 32'h0, 1, 1};
    vecs[13] = '{6'd1, 5'd16, 32'h0,         32'h0, 1, 0};
    vecs[14] = '{6'd1, 5'd2,  32'hFFFF_FFFF, 32'h0, 0, 0};
    vecs[15] = '{6'd0, 5'd0,  32'h5,         32'h5, 0, 0};
    vecs[16] = '{6'd2, 5'd1,  32'h5,         32'h5, 0, 0};

    do_reset();
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_taken", {31'd0, res_taken}, 32'd0);

    // Decode table: previous res_taken set opposite so hold/update is visible
    for (int i = 0; i < 17; i++) begin
      apply(0, 1, 0, 0, 6'd4, 5'd0, 32'd1, {31'd0, ~vecs[i].tk}, 32'h800, 0, 32'h800);
      apply(0, 1, 0, 0, vecs[i].op, vecs[i].rt, vecs[i].a, vecs[i].b,
            32'h1000 + 32'(4 * i), 0, 32'h1000);
      check("tbl_valid", {31'd0, res_valid}, {31'd0, vecs[i].br});
      if (vecs[i].br) check("tbl_taken", {31'd0, res_taken}, {31'd0, vecs[i].tk});
      else            check("tbl_hold", {31'd0, res_taken}, {31'd0, ~vecs[i].tk});
    end

    // Every index starts weakly not taken
    do_reset();
    for (int i = 0; i < PHT_DEPTH; i++) begin
      apply(0, 1, 0, 0, 6'd4, 5'd0, 32'd3, 32'd3, 32'(4 * i), 0, 32'(4 * i));
      check("init_pre", {31'd0, pred_taken}, 32'd1);
    end

    do_reset();
    apply(0, 0, 0, 0, 6'd0, 5'd0, 32'd0, 32'd0, 32'd0, 0, 32'h100);
    check("reset_pred", {31'd0, pred_taken}, 32'd0);
    apply(0, 1, 0, 0, 6'd4, 5'd0, 32'h5, 32'h5, 32'h100, 0, 32'h100);
    check("beq_valid", {31'd0, res_valid}, 32'd1);
    check("beq_taken", {31'd0, res_taken}, 32'd1);
    check("beq_mis", {31'd0, mispredict}, 32'd1);
    check("beq_pred_after", {31'd0, pred_taken}, 32'd1);

    apply(0, 1, 0, 0, 6'd1, 5'd17, 32'h8000_0000, 32'd0, 32'h104, 1, 32'h0);
    check("bgezal_taken", {31'd0, res_taken}, 32'd0);
    apply(0, 1, 0, 0, 6'd1, 5'd0, 32'h8000_0000, 32'd0, 32'h108, 0, 32'h0);
    check("bltz_taken", {31'd0, res_taken}, 32'd1);

    do_reset();
    for (int i = 0; i < 4; i++)
      apply(0, 1, 0, 0, 6'd5, 5'd0, 32'd1, 32'd2, 32'h200, 1, 32'h200);
    apply(0, 1, 0, 0, 6'd5, 5'd0, 32'd2, 32'd2, 32'h200, 1, 32'h200);
    check("bne_nt_mis", {31'd0, mispredict}, 32'd1);
    check("sat_then_dec", {31'd0, pred_taken}, 32'd1);
    apply(0, 1, 0, 0, 6'd5, 5'd0, 32'd2, 32'd2, 32'h200, 1, 32'h200);
    check("dec_to_01", {31'd0, pred_taken}, 32'd0);

    // Blocked acceptances leave the table alone
    apply(0, 1, 1, 0, 6'd4, 5'd0, 32'd9, 32'd9, 32'h300, 0, 32'h300);
    check("stall_valid", {31'd0, res_valid}, 32'd0);
    apply(0, 1, 0, 1, 6'd4, 5'd0, 32'd9, 32'd9, 32'h300, 0, 32'h300);
    check("flush_valid", {31'd0, res_valid}, 32'd0);
    apply(0, 1, 1, 1, 6'd4, 5'd0, 32'd9, 32'd9, 32'h300, 0, 32'h300);
    check("both_valid", {31'd0, res_valid}, 32'd0);
    apply(0, 1, 0, 0, 6'd4, 5'd0, 32'd9, 32'd9, 32'h304, 0, 32'h300);
    check("blocked_pht", {31'd0, pred_taken}, 32'd0);
    apply(1, 1, 0, 0, 6'd4, 5'd0, 32'd9, 32'd9, 32'h300, 0, 32'h300);
    check("rst_br_valid", {31'd0, res_valid}, 32'd0);
    check("rst_br_pht", {31'd0, pred_taken}, 32'd0);

    // Randomized traffic, narrow PC range so entries collide and alias
    for (int n = 0; n < 500; n++) begin
      logic [5:0]  op;
      logic [4:0]  rt;
      logic [31:0] a, b, pc, ipc;
      int sel;
      sel = $urandom_range(0, 7);
      op = (sel == 0) ? 6'd4 : (sel == 1) ? 6'd5 : (sel == 2) ? 6'd6 : (sel == 3) ? 6'd7 :
           (sel <= 5) ? 6'd1 : 6'($urandom_range(0, 63));
      rt = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 31))
                                       : (($urandom_range(0, 1) == 1) ? 5'd16 : 5'd0) |
                                         5'($urandom_range(0, 1));
      a  = ($urandom_range(0, 1) == 1) ? pick_vals[$urandom_range(0, 5)] : $urandom;
      b  = ($urandom_range(0, 1) == 1) ? a : pick_vals[$urandom_range(0, 5)];
      pc = 32'h100 + 32'(4 * $urandom_range(0, 7)) + (($urandom_range(0, 3) == 0) ? 32'(4 * PHT_DEPTH) : 32'd0);
      ipc = ($urandom_range(0, 1) == 1) ? pc : 32'h100 + 32'(4 * $urandom_range(0, 7));
      apply(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 8),
            ($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0),
            op, rt, a, b, pc, 1'($urandom_range(0, 1)), ipc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
